// File: rtl/wait_pass_pkg.sv
// Shared widths and defaults for the write_tohost completion monitor.
package wait_pass_pkg;
  localparam int          CNT_W              = 32;
  localparam logic [31:0] CNT_MAX            = 32'hFFFF_FFFF;
  localparam logic [63:0] TOHOST_PC_DEFAULT  = 64'h0000_0000_8000_0040;
endpackage

// File: rtl/wait_pass_monitor_sat_counter.sv
// Saturating up-counter; sticks at CNT_MAX instead of wrapping.
module sat_counter
  import wait_pass_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       count <= '0;
    else if (inc && count != CNT_MAX) count <= count + 1'b1;
  end
endmodule

// File: rtl/wait_pass_monitor.sv
// Counts retirements at the write_tohost PC and timestamps the first one.
module wait_pass_monitor
  import wait_pass_pkg::*;
#(
  parameter int              PC_W      = 64,
  parameter logic [PC_W-1:0] TOHOST_PC = PC_W'(TOHOST_PC_DEFAULT)
) (
  input  logic             tb_clk,
  input  logic             tb_rst_n,
  output logic [CNT_W-1:0] pc_write_to_host_cnt,
  output logic [CNT_W-1:0] pc_write_to_host_cycle,
  output logic [CNT_W-1:0] valid_ir_cycle,
  output logic [CNT_W-1:0] cycle_count,
  input  logic             ir_valid,
  input  logic [PC_W-1:0]  ir_pc
);
  logic hit;

  // ir_valid gates first so an X PC on idle cycles can never produce a hit
  assign hit = ir_valid && (ir_pc == TOHOST_PC);

  sat_counter u_cycle_cnt (
    .clk   (tb_clk),
    .rst_n (tb_rst_n),
    .inc   (1'b1),
    .count (cycle_count)
  );

  sat_counter u_valid_cnt (
    .clk   (tb_clk),
    .rst_n (tb_rst_n),
    .inc   (ir_valid),
    .count (valid_ir_cycle)
  );

  sat_counter u_hit_cnt (
    .clk   (tb_clk),
    .rst_n (tb_rst_n),
    .inc   (hit),
    .count (pc_write_to_host_cnt)
  );

  // Only the first hit after reset is timestamped, using the pre-increment cycle count
  always_ff @(posedge tb_clk or negedge tb_rst_n) begin
    if (!tb_rst_n)                           pc_write_to_host_cycle <= '0;
    else if (hit && pc_write_to_host_cnt == '0) pc_write_to_host_cycle <= cycle_count;
  end
endmodule

// File: tb/tb_wait_pass_monitor.sv
// Directed bench for wait_pass_monitor: reset, counting, first-hit capture, saturation, async reset.
module tb_wait_pass_monitor;
  localparam logic [63:0] TOHOST = 64'h0000_0000_8000_0040;

  logic        tb_clk = 1'b0;
  logic        tb_rst_n = 1'b0;
  logic [31:0] pc_write_to_host_cnt, pc_write_to_host_cycle, valid_ir_cycle, cycle_count;
  logic        ir_valid = 1'b0;
  logic [63:0] ir_pc = '0;

  int n_chk  = 0;
  int n_pass = 0;

  wait_pass_monitor dut (
    .tb_clk                 (tb_clk),
    .tb_rst_n               (tb_rst_n),
    .pc_write_to_host_cnt   (pc_write_to_host_cnt),
    .pc_write_to_host_cycle (pc_write_to_host_cycle),
    .valid_ir_cycle         (valid_ir_cycle),
    .cycle_count            (cycle_count),
    .ir_valid               (ir_valid),
    .ir_pc                  (ir_pc)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_cnt, input logic [31:0] e_cyc,
                         input logic [31:0] e_val, input logic [31:0] e_cc);
    chk({tag, ".hit_cnt"},   pc_write_to_host_cnt,   e_cnt);
    chk({tag, ".hit_cycle"}, pc_write_to_host_cycle, e_cyc);
    chk({tag, ".valid"},     valid_ir_cycle,         e_val);
    chk({tag, ".cycles"},    cycle_count,            e_cc);
  endtask

  // Drive inputs on the falling edge, hold for n rising edges, return on a falling edge.
  task automatic drive(input logic v, input logic [63:0] pc, input int n);
    ir_valid = v;
    ir_pc    = pc;
    repeat (n) @(negedge tb_clk);
  endtask

  initial begin
    repeat (3) @(negedge tb_clk);
    chk_all("reset", 0, 0, 0, 0);

    tb_rst_n = 1'b1;
    drive(1'b0, '0, 10);
    chk_all("idle10", 0, 0, 0, 10);

    drive(1'b1, 64'h8000_0000, 6);
    chk_all("valid6", 0, 0, 6, 16);

    // edges 17..19 idle (X PC with ir_valid low), first hit on edge 20
    drive(1'b0, 64'hx, 3);
    chk_all("pre_hit", 0, 0, 6, 19);
    drive(1'b1, TOHOST, 1);
    chk_all("first_hit", 1, 19, 7, 20);

    // 7 more hits, each after a near-miss PC differing only in the upper bits
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 64'h0000_0001_8000_0040, 1);
      drive(1'b1, TOHOST, 1);
    end
    chk_all("hits8", 8, 19, 21, 34);

    drive(1'b0, TOHOST, 5);
    chk_all("invalid_tohost", 8, 19, 21, 39);

    // preload every counter just below saturation, then 3 hit cycles
    force dut.u_cycle_cnt.count = 32'hFFFF_FFFE;
    force dut.u_valid_cnt.count = 32'hFFFF_FFFE;
    force dut.u_hit_cnt.count   = 32'hFFFF_FFFE;
    #1;
    release dut.u_cycle_cnt.count;
    release dut.u_valid_cnt.count;
    release dut.u_hit_cnt.count;
    drive(1'b1, TOHOST, 3);
    chk_all("saturate", 32'hFFFF_FFFF, 19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // async reset between edges
    #2;
    tb_rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0);
    @(negedge tb_clk);
    tb_rst_n = 1'b1;
    drive(1'b0, '0, 2);
    drive(1'b1, TOHOST, 1);
    chk_all("recapture", 1, 2, 1, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
